// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller slice.
//   sw_state_t : controller states
//   BCD_W / NUM_DIGITS / DIGITS_W : digit bus geometry
//   BTN_SS / BTN_LC : button indices (start/stop, lap/clear)
package stopwatch_pkg;

   typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} sw_state_t;

   localparam int BCD_W      = 4;
   localparam int NUM_DIGITS = 6;
   localparam int DIGITS_W   = BCD_W * NUM_DIGITS;
   localparam int NUM_BTNS   = 2;
   localparam int BTN_SS     = 0;
   localparam int BTN_LC     = 1;

endpackage

// File: rtl/stopwatch_chain_if.sv
// Link between the controller and the cascaded BCD counter chain.
//   live_digits : current chain digits, [3:0] = least significant
//   chain_wrap  : one-cycle pulse when the chain rolls 999999 -> 000000
//   count_en    : one-cycle enable into the least significant counter
//   count_clr   : synchronous clear of every counter
// master = controller side, slave = counter chain side.
interface stopwatch_chain_if;
   import stopwatch_pkg::*;

   logic [DIGITS_W-1:0] live_digits;
   logic                chain_wrap;
   logic                count_en;
   logic                count_clr;

   modport master (
      input  live_digits, chain_wrap,
      output count_en, count_clr
   );

   modport slave (
      input  count_en, count_clr,
      output live_digits, chain_wrap
   );

endinterface

// File: rtl/button_debouncer.sv
// Synchronises and debounces one active-low push button.
//   clock, reset_n : system clock, async active-low reset
//   raw            : raw button level (0 = pressed)
//   press          : one-cycle pulse when the accepted level goes 1 -> 0
// A level is accepted after DB_CYCLES consecutive synchronised samples that
// differ from the current accepted level; any bounce restarts the count.
module button_debouncer #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic press
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;
   logic          diff;
   logic          done;

   assign diff = (sync[1] != level);
   assign done = diff && (cnt == CNT_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         press <= done && !sync[1];
         if (!diff || done) cnt <= '0;
         else               cnt <= cnt + 1'b1;
         if (done) level <= sync[1];
      end
   end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: start/stop, lap freeze and clear of a six-digit BCD
// counter chain, centisecond enable generation and registered display bus.
//   clock, reset_n : system clock, async active-low reset
//   buttons        : raw active-low buttons, [0] start/stop, [1] lap/clear
//   chain          : counter chain link (live digits, wrap, enable, clear)
//   disp_digits    : registered digits to the seven-segment decoders
//   running        : high in RUN or LAP
//   lap_active     : high in LAP
//   overflow       : sticky, set when the chain wraps while counting
module stopwatch_controller
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 100,
   parameter int DB_CYCLES = 500000
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NUM_BTNS-1:0]  buttons,
   stopwatch_chain_if.master    chain,
   output logic [DIGITS_W-1:0]  disp_digits,
   output logic                 running,
   output logic                 lap_active,
   output logic                 overflow
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic [NUM_BTNS-1:0] press;
   sw_state_t           state, state_nxt;
   logic [PW-1:0]       presc;
   logic                clr_q, clr_nxt;
   logic                ovf_nxt;
   logic                counting;
   logic [DIGITS_W-1:0] lap_reg, lap_nxt;

   button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_BTNS-1:0] (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (buttons),
      .press   (press)
   );

   assign counting        = (state == RUN) || (state == LAP);
   assign running         = counting;
   assign lap_active      = (state == LAP);
   // Decided from the present state only, so a press in the same cycle
   // never swallows the tick.
   assign chain.count_en  = counting && (presc == PRE_LAST);
   assign chain.count_clr = clr_q;

   always_comb begin
      state_nxt = state;
      clr_nxt   = 1'b0;
      ovf_nxt   = overflow;
      lap_nxt   = lap_reg;
      if (counting && chain.chain_wrap) begin
         // Wrap outranks any press arriving in the same cycle.
         ovf_nxt   = 1'b1;
         state_nxt = STOP;
      end else if (press[BTN_SS]) begin
         // start/stop outranks a simultaneous lap/clear
         case (state)
            IDLE, STOP: state_nxt = RUN;
            default:    state_nxt = STOP;
         endcase
      end else if (press[BTN_LC]) begin
         case (state)
            IDLE: clr_nxt = 1'b1;
            RUN: begin
               state_nxt = LAP;
               lap_nxt   = chain.live_digits;
            end
            LAP: state_nxt = RUN;
            default: begin
               clr_nxt   = 1'b1;
               ovf_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         presc       <= '0;
         clr_q       <= 1'b1;
         lap_reg     <= '0;
         overflow    <= 1'b0;
         disp_digits <= '0;
      end else begin
         state       <= state_nxt;
         clr_q       <= clr_nxt;
         lap_reg     <= lap_nxt;
         overflow    <= ovf_nxt;
         disp_digits <= (state_nxt == LAP) ? lap_nxt : chain.live_digits;
         // Holding in STOP keeps the fractional centisecond.
         if (clr_q)         presc <= '0;
         else if (counting) presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
      end
   end

endmodule
